// File: rtl/deco_frame_feeder.sv
// Feeds one coded frame to the Deco turbo decoder as a burst of beats and
// returns the decoded word (or a timeout error indication) over valid/ready.
module deco_frame_feeder #(
   parameter int unsigned BEAT_W    = 21,
   parameter int unsigned NUM_BEATS = 4,
   parameter int unsigned RES_W     = 5,
   parameter int unsigned TIMEOUT   = 1023,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                        clk_p_i,
   input  logic                        reset_n_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [BEAT_W*NUM_BEATS-1:0] in_frame_i,
   output logic                        start_o,
   output logic [BEAT_W-1:0]           data_o,
   input  logic                        done_i,
   input  logic [RES_W-1:0]            result_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [RES_W-1:0]            res_data_o,
   output logic                        res_err_o,
   output logic [CNT_W-1:0]            frame_cnt_o,
   output logic                        proto_err_o
);

   localparam int unsigned BIDX_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   // Counter only needs to reach TIMEOUT-1: the limit is detected on that cycle.
   localparam int unsigned TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BIDX_W-1:0] LastBeat = BIDX_W'(NUM_BEATS - 1);
   localparam logic [TMO_W-1:0]  TmoLast  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWait,
      StOut
   } state_e;

   state_e                           state_q;
   logic [NUM_BEATS-1:0][BEAT_W-1:0] frame_q;
   logic [BIDX_W-1:0]                beat_q;
   logic [BIDX_W-1:0]                beat_nxt;
   logic [TMO_W-1:0]                 tmo_q;

   assign beat_nxt = beat_q + BIDX_W'(1);

   always_ff @(posedge clk_p_i) begin
      if (!reset_n_i) begin
         state_q     <= StIdle;
         frame_q     <= '0;
         beat_q      <= '0;
         tmo_q       <= '0;
         in_ready_o  <= 1'b1;
         start_o     <= 1'b0;
         data_o      <= '0;
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         res_err_o   <= 1'b0;
         frame_cnt_o <= '0;
         proto_err_o <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i && in_ready_o) begin
                  frame_q    <= in_frame_i;
                  data_o     <= in_frame_i[BEAT_W-1:0];
                  start_o    <= 1'b1;
                  in_ready_o <= 1'b0;
                  beat_q     <= '0;
                  state_q    <= StSend;
               end
            end
            StSend: begin
               if (beat_q == LastBeat) begin
                  tmo_q   <= '0;
                  state_q <= StWait;
               end else begin
                  data_o <= frame_q[beat_nxt];
                  beat_q <= beat_nxt;
               end
            end
            StWait: begin
               // A done on the limit cycle still delivers the real result.
               if (done_i) begin
                  res_data_o  <= result_i;
                  res_err_o   <= 1'b0;
                  res_valid_o <= 1'b1;
                  start_o     <= 1'b0;
                  data_o      <= '0;
                  state_q     <= StOut;
               end else if (tmo_q == TmoLast) begin
                  res_data_o  <= '0;
                  res_err_o   <= 1'b1;
                  res_valid_o <= 1'b1;
                  start_o     <= 1'b0;
                  data_o      <= '0;
                  state_q     <= StOut;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            StOut: begin
               if (res_valid_o && res_ready_i) begin
                  res_valid_o <= 1'b0;
                  frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                  in_ready_o  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (done_i && (state_q != StWait)) begin
            proto_err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_deco_frame_feeder.sv
// Directed bench for deco_frame_feeder: a per-cycle vector table for the basic
// frame plus hand sequences for timeout, stall, protocol error and reset cases.
module tb_deco_frame_feeder;

   localparam int unsigned BW = 21;
   localparam int unsigned NB = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [BW*NB-1:0] in_frame;
   logic            start;
   logic [BW-1:0]   data;
   logic            done;
   logic [4:0]      result;
   logic            res_valid;
   logic            res_ready;
   logic [4:0]      res_data;
   logic            res_err;
   logic [15:0]     frame_cnt;
   logic            proto_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   deco_frame_feeder #(
      .BEAT_W   (BW),
      .NUM_BEATS(NB),
      .RES_W    (5),
      .TIMEOUT  (8),
      .CNT_W    (16)
   ) dut (
      .clk_p_i    (clk),
      .reset_n_i  (reset_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_frame_i (in_frame),
      .start_o    (start),
      .data_o     (data),
      .done_i     (done),
      .result_i   (result),
      .res_valid_o(res_valid),
      .res_ready_i(res_ready),
      .res_data_o (res_data),
      .res_err_o  (res_err),
      .frame_cnt_o(frame_cnt),
      .proto_err_o(proto_err)
   );

   typedef struct {
      logic        vld;
      logic        dn;
      logic [4:0]  res;
      logic        rdy;
      logic        e_ir;
      logic        e_st;
      logic [20:0] e_d;
      logic        e_rv;
      logic [4:0]  e_rd;
      logic        e_re;
      logic [15:0] e_cnt;
      logic        e_pe;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] get_beat(input logic [83:0] f, input int i);
      return f[i*21 +: 21];
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Accept a frame from IDLE, check the beats, leave the bench observing WAIT cycle 1.
   task automatic run_to_wait(input logic [83:0] f);
      in_valid = 1'b1;
      in_frame = f;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("beat_start", start, 1'b1);
         chk("beat_data", data, get_beat(f, i));
         step();
      end
      chk("wait_data", data, get_beat(f, 3));
   endtask

   logic [83:0] f1, f2, f3, f4;
   logic [83:0] frames[3];
   logic [4:0]  rvals[3];
   vec_t        tbl[11];

   initial begin
      f1 = {21'h1F0F0F, 21'h0AAAAA, 21'h155555, 21'h0F0F0F};
      f2 = {21'h000001, 21'h123456, 21'h1FFFFF, 21'h0ABCDE};
      f3 = {21'h1C0003, 21'h00F00F, 21'h111111, 21'h02468A};
      f4 = {21'h054321, 21'h1E1E1E, 21'h000000, 21'h13579B};

      //        vld dn res       rdy ir st data        rv rd        re cnt pe
      tbl[0]  = '{1, 0, 5'h00, 0, 0, 1, 21'h0F0F0F, 0, 5'h00, 0, 0, 0};
      tbl[1]  = '{0, 0, 5'h00, 0, 0, 1, 21'h155555, 0, 5'h00, 0, 0, 0};
      tbl[2]  = '{0, 0, 5'h00, 0, 0, 1, 21'h0AAAAA, 0, 5'h00, 0, 0, 0};
      tbl[3]  = '{0, 0, 5'h00, 0, 0, 1, 21'h1F0F0F, 0, 5'h00, 0, 0, 0};
      tbl[4]  = '{0, 0, 5'h00, 0, 0, 1, 21'h1F0F0F, 0, 5'h00, 0, 0, 0};
      tbl[5]  = '{0, 0, 5'h00, 0, 0, 1, 21'h1F0F0F, 0, 5'h00, 0, 0, 0};
      tbl[6]  = '{0, 0, 5'h00, 0, 0, 1, 21'h1F0F0F, 0, 5'h00, 0, 0, 0};
      tbl[7]  = '{0, 1, 5'h16, 0, 0, 0, 21'h000000, 1, 5'h16, 0, 0, 0};
      tbl[8]  = '{0, 0, 5'h00, 0, 0, 0, 21'h000000, 1, 5'h16, 0, 0, 0};
      tbl[9]  = '{0, 0, 5'h00, 1, 1, 0, 21'h000000, 0, 5'h16, 0, 1, 0};
      tbl[10] = '{0, 0, 5'h00, 0, 1, 0, 21'h000000, 0, 5'h16, 0, 1, 0};

      in_valid  = 1'b0;
      in_frame  = '0;
      done      = 1'b0;
      result    = '0;
      res_ready = 1'b0;

      // Reset state
      do_reset();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_start", start, 1'b0);
      chk("rst_data", data, 21'h0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, 5'h0);
      chk("rst_res_err", res_err, 1'b0);
      chk("rst_frame_cnt", frame_cnt, 16'h0);
      chk("rst_proto_err", proto_err, 1'b0);

      // Basic frame, one vector per clock
      in_frame = f1;
      for (int i = 0; i < 11; i++) begin
         in_valid  = tbl[i].vld;
         done      = tbl[i].dn;
         result    = tbl[i].res;
         res_ready = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("vec%0d_start", i), start, tbl[i].e_st);
         chk($sformatf("vec%0d_data", i), data, tbl[i].e_d);
         chk($sformatf("vec%0d_res_valid", i), res_valid, tbl[i].e_rv);
         chk($sformatf("vec%0d_res_data", i), res_data, tbl[i].e_rd);
         chk($sformatf("vec%0d_res_err", i), res_err, tbl[i].e_re);
         chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, tbl[i].e_cnt);
         chk($sformatf("vec%0d_proto_err", i), proto_err, tbl[i].e_pe);
      end
      in_valid  = 1'b0;
      done      = 1'b0;
      res_ready = 1'b0;

      // Timeout: no done for 8 WAIT cycles
      run_to_wait(f2);
      for (int i = 1; i < 8; i++) begin
         chk("tmo_start_held", start, 1'b1);
         chk("tmo_no_valid", res_valid, 1'b0);
         step();
      end
      chk("tmo_start_w8", start, 1'b1);
      step();
      chk("tmo_start_drop", start, 1'b0);
      chk("tmo_res_valid", res_valid, 1'b1);
      chk("tmo_res_err", res_err, 1'b1);
      chk("tmo_res_data", res_data, 5'h0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("tmo_frame_cnt", frame_cnt, 16'd2);

      // Done on the limit cycle wins over timeout
      run_to_wait(f3);
      for (int i = 1; i < 8; i++) step();
      done   = 1'b1;
      result = 5'h13;
      step();
      done = 1'b0;
      chk("lim_res_valid", res_valid, 1'b1);
      chk("lim_res_err", res_err, 1'b0);
      chk("lim_res_data", res_data, 5'h13);
      chk("lim_proto_err", proto_err, 1'b0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("lim_frame_cnt", frame_cnt, 16'd3);

      // Downstream stall for 10 cycles
      do_reset();
      run_to_wait(f2);
      done   = 1'b1;
      result = 5'h0B;
      step();
      done     = 1'b0;
      in_valid = 1'b1;
      in_frame = f3;
      for (int i = 0; i < 10; i++) begin
         chk("stall_res_valid", res_valid, 1'b1);
         chk("stall_res_data", res_data, 5'h0B);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_start", start, 1'b0);
         step();
      end
      res_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      res_ready = 1'b0;
      chk("stall_rel_valid", res_valid, 1'b0);
      chk("stall_rel_in_ready", in_ready, 1'b1);
      chk("stall_rel_cnt", frame_cnt, 16'd1);

      // Spurious done while beat 1 is on the bus
      do_reset();
      in_valid = 1'b1;
      in_frame = f4;
      step();
      in_valid = 1'b0;
      step();
      chk("spur_beat1", data, get_beat(f4, 1));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("spur_proto_err", proto_err, 1'b1);
      chk("spur_beat2", data, get_beat(f4, 2));
      chk("spur_no_valid", res_valid, 1'b0);
      step();
      chk("spur_beat3", data, get_beat(f4, 3));
      step();
      chk("spur_wait_start", start, 1'b1);
      done   = 1'b1;
      result = 5'h07;
      step();
      done = 1'b0;
      chk("spur_res_data", res_data, 5'h07);
      chk("spur_res_err", res_err, 1'b0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("spur_frame_cnt", frame_cnt, 16'd1);
      chk("spur_proto_sticky", proto_err, 1'b1);

      // Reset while waiting on Deco
      run_to_wait(f1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("rw_start", start, 1'b0);
      chk("rw_in_ready", in_ready, 1'b1);
      chk("rw_frame_cnt", frame_cnt, 16'd0);
      chk("rw_proto_err", proto_err, 1'b0);
      chk("rw_data", data, 21'h0);
      run_to_wait(f2);
      done   = 1'b1;
      result = 5'h1C;
      step();
      done = 1'b0;
      chk("rw_res_valid", res_valid, 1'b1);
      chk("rw_res_data", res_data, 5'h1C);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("rw_frame_cnt2", frame_cnt, 16'd1);

      // Back-to-back frames with downstream always ready
      do_reset();
      frames[0] = f2;
      frames[1] = f3;
      frames[2] = f4;
      rvals[0]  = 5'h05;
      rvals[1]  = 5'h1A;
      rvals[2]  = 5'h11;
      res_ready = 1'b1;
      begin
         int k_acc = 0;
         int k_res = 0;
         int run   = 0;
         int gap   = 0;
         bit seen  = 1'b0;
         for (int cyc = 0; cyc < 80 && k_res < 3; cyc++) begin
            if (start) begin
               if (run == 0 && seen) chk("b2b_gap", gap, 2);
               chk("b2b_beat", data,
                   get_beat(frames[(k_acc == 0) ? 0 : k_acc - 1], (run < 4) ? run : 3));
               done   = (run == 4);
               result = rvals[(k_acc == 0) ? 0 : k_acc - 1];
               run++;
               gap  = 0;
               seen = 1'b1;
            end else begin
               done = 1'b0;
               run  = 0;
               if (seen) gap++;
            end
            if (res_valid && k_res < 3) begin
               chk("b2b_result", res_data, rvals[k_res]);
               k_res++;
            end
            in_valid = (k_acc < 3);
            in_frame = frames[(k_acc < 3) ? k_acc : 2];
            if (in_ready && k_acc < 3) k_acc++;
            step();
         end
         done     = 1'b0;
         in_valid = 1'b0;
         chk("b2b_all_results", k_res, 3);
         chk("b2b_frame_cnt", frame_cnt, 16'd3);
      end
      res_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
